board_cursor_ctrl: RTL and testbench

BOARD_CURSOR_CTRL -- requirements
Module: board_cursor_ctrl

---
 rtl/board_cursor_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_board_cursor_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/board_cursor_ctrl.sv
// rtl/board_cursor_ctrl.sv - keyboard-driven board cursor with auto-repeat and source/destination selection (option: CURSOR_WRAP_EN)
module board_cursor_ctrl #(
  parameter int BOARD_W      = 8,
  parameter int BOARD_H      = 8,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [10:0] key_event,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y,
  output logic        is_pressed,
  output logic [3:0]  src_x,
  output logic [3:0]  src_y,
  output logic        src_valid,
  output logic        move_valid,
  output logic [3:0]  dst_x,
  output logic [3:0]  dst_y
);

  localparam logic [7:0] CODE_W   = 8'h1D;
  localparam logic [7:0] CODE_S   = 8'h1B;
  localparam logic [7:0] CODE_A   = 8'h1C;
  localparam logic [7:0] CODE_D   = 8'h23;
  localparam logic [7:0] CODE_G   = 8'h34;
  localparam logic [7:0] CODE_ESC = 8'h76;

  localparam logic [3:0] X_MAX = 4'(BOARD_W - 1);
  localparam logic [3:0] Y_MAX = 4'(BOARD_H - 1);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  typedef enum logic {IDLE, SRC_HELD} state_t;

  state_t        state, state_next;
  logic          held_valid;
  logic [7:0]    held_code;
  logic [CW-1:0] cnt;
  logic          first_rpt;

  logic       ev_ok, ev_make, ev_break, is_dir;
  logic       dir_make, g_make, esc_make, held_release;
  logic       rpt_fire, step_en;
  logic [7:0] code, step_code;
  logic       latch_src, do_move;

  // Step one cell down/up; at the edge either stay put or wrap to the far side.
  function automatic logic [3:0] step_dec(input logic [3:0] v, input logic [3:0] vmax);
`ifdef CURSOR_WRAP_EN
    return (v == 4'd0) ? vmax : v - 4'd1;
`else
    return (v == 4'd0) ? v : v - 4'd1;
`endif
  endfunction

  function automatic logic [3:0] step_inc(input logic [3:0] v, input logic [3:0] vmax);
`ifdef CURSOR_WRAP_EN
    return (v == vmax) ? 4'd0 : v + 4'd1;
`else
    return (v == vmax) ? v : v + 4'd1;
`endif
  endfunction

  // Event decode: only valid, non-extended events are considered.
  always_comb begin
    code         = key_event[7:0];
    ev_ok        = key_event[10] & ~key_event[9];
    ev_make      = ev_ok & ~key_event[8];
    ev_break     = ev_ok & key_event[8];
    is_dir       = (code == CODE_W) | (code == CODE_S) | (code == CODE_A) | (code == CODE_D);
    dir_make     = ev_make & is_dir;
    g_make       = ev_make & (code == CODE_G);
    esc_make     = ev_make & (code == CODE_ESC);
    held_release = ev_break & held_valid & (code == held_code);
    // A break or a fresh make in the same cycle wins over a pending repeat step.
    rpt_fire     = held_valid & ~held_release & ~dir_make &
                   (first_rpt ? (cnt == DELAY_LAST) : (cnt == RATE_LAST));
    step_en      = dir_make | rpt_fire;
    step_code    = dir_make ? code : held_code;
  end

  // Cursor position, held key and auto-repeat counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cursor_x   <= 4'd0;
      cursor_y   <= 4'd0;
      held_valid <= 1'b0;
      held_code  <= 8'd0;
      cnt        <= '0;
      first_rpt  <= 1'b1;
    end else begin
      if (step_en) begin
        case (step_code)
          CODE_W:  cursor_y <= step_dec(cursor_y, Y_MAX);
          CODE_S:  cursor_y <= step_inc(cursor_y, Y_MAX);
          CODE_A:  cursor_x <= step_dec(cursor_x, X_MAX);
          CODE_D:  cursor_x <= step_inc(cursor_x, X_MAX);
          default: ;
        endcase
      end
      if (dir_make) begin
        held_valid <= 1'b1;
        held_code  <= code;
        cnt        <= '0;
        first_rpt  <= 1'b1;
      end else if (held_release) begin
        held_valid <= 1'b0;
        cnt        <= '0;
        first_rpt  <= 1'b1;
      end else if (held_valid) begin
        if (rpt_fire) begin
          cnt       <= '0;
          first_rpt <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Select FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Select FSM next state: first G picks the source, second G moves or cancels.
  always_comb begin
    state_next = state;
    latch_src  = 1'b0;
    do_move    = 1'b0;
    case (state)
      IDLE: begin
        if (g_make) begin
          latch_src  = 1'b1;
          state_next = SRC_HELD;
        end
      end
      SRC_HELD: begin
        if (g_make) begin
          state_next = IDLE;
          do_move    = (cursor_x != src_x) | (cursor_y != src_y);
        end else if (esc_make) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered selection outputs; coordinates hold their last value between uses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_x      <= 4'd0;
      src_y      <= 4'd0;
      dst_x      <= 4'd0;
      dst_y      <= 4'd0;
      move_valid <= 1'b0;
      is_pressed <= 1'b0;
    end else begin
      move_valid <= do_move;
      is_pressed <= g_make;
      if (latch_src) begin
        src_x <= cursor_x;
        src_y <= cursor_y;
      end
      if (do_move) begin
        dst_x <= cursor_x;
        dst_y <= cursor_y;
      end
    end
  end

  assign src_valid = (state == SRC_HELD);

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// tb/tb_board_cursor_ctrl.sv - directed self-checking bench for board_cursor_ctrl (option: CURSOR_WRAP_EN)
module tb_board_cursor_ctrl;

  localparam logic [7:0] K_W   = 8'h1D;
  localparam logic [7:0] K_S   = 8'h1B;
  localparam logic [7:0] K_A   = 8'h1C;
  localparam logic [7:0] K_D   = 8'h23;
  localparam logic [7:0] K_G   = 8'h34;
  localparam logic [7:0] K_ESC = 8'h76;

  logic        clk;
  logic        rstn;
  logic [10:0] key_event;
  logic [3:0]  cursor_x, cursor_y, src_x, src_y, dst_x, dst_y;
  logic        is_pressed, src_valid, move_valid;

  int total;
  int bad;

  board_cursor_ctrl #(
    .BOARD_W(8),
    .BOARD_H(8),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .key_event(key_event),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .is_pressed(is_pressed),
    .src_x(src_x),
    .src_y(src_y),
    .src_valid(src_valid),
    .move_valid(move_valid),
    .dst_x(dst_x),
    .dst_y(dst_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: strobe is sampled on the next rising edge.
  task automatic send(input logic ext, input logic brk, input logic [7:0] code);
    key_event = {1'b1, ext, brk, code};
    @(negedge clk);
    key_event = 11'd0;
  endtask

  task automatic tap(input logic [7:0] code);
    send(1'b0, 1'b0, code);
    send(1'b0, 1'b1, code);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b0;
    key_event = 11'd0;

    #2;
    check("rst_x", 16'(cursor_x), 16'd0);
    check("rst_y", 16'(cursor_y), 16'd0);
    check("rst_src_valid", 16'(src_valid), 16'd0);
    check("rst_move_valid", 16'(move_valid), 16'd0);
    check("rst_is_pressed", 16'(is_pressed), 16'd0);
    check("rst_src", 16'({src_x, src_y}), 16'd0);
    check("rst_dst", 16'({dst_x, dst_y}), 16'd0);
    idle(2);
    rstn = 1'b1;
    @(negedge clk);

    // Short D press: exactly one step.
    send(1'b0, 1'b0, K_D);
    check("tap_d_first_step", 16'(cursor_x), 16'd1);
    idle(2);
    send(1'b0, 1'b1, K_D);
    idle(15);
    check("tap_d_single_step", 16'(cursor_x), 16'd1);
    check("tap_d_y", 16'(cursor_y), 16'd0);

    // S held 22 cycles: steps at +1, +11, +15, +19.
    do_reset();
    send(1'b0, 1'b0, K_S);
    check("hold_s_c1", 16'(cursor_y), 16'd1);
    idle(9);
    check("hold_s_c10", 16'(cursor_y), 16'd1);
    idle(1);
    check("hold_s_c11", 16'(cursor_y), 16'd2);
    idle(4);
    check("hold_s_c15", 16'(cursor_y), 16'd3);
    idle(6);
    send(1'b0, 1'b1, K_S);
    check("hold_s_release", 16'(cursor_y), 16'd4);
    idle(12);
    check("hold_s_no_more", 16'(cursor_y), 16'd4);

    // Edge behaviour at (0,0), plus ignored codes.
    do_reset();
    tap(K_W);
    tap(K_A);
`ifdef CURSOR_WRAP_EN
    check("edge_x", 16'(cursor_x), 16'd7);
    check("edge_y", 16'(cursor_y), 16'd7);
`else
    check("edge_x", 16'(cursor_x), 16'd0);
    check("edge_y", 16'(cursor_y), 16'd0);
`endif
    do_reset();
    tap(8'h15);
    send(1'b1, 1'b0, K_D);
    send(1'b1, 1'b1, K_D);
    check("ignored_codes", 16'({cursor_x, cursor_y}), 16'h00);

    // Move from (2,3) to (5,3).
    do_reset();
    tap(K_D);
    tap(K_D);
    tap(K_S);
    tap(K_S);
    tap(K_S);
    check("mv_cursor", 16'({cursor_x, cursor_y}), 16'h23);
    send(1'b0, 1'b0, K_G);
    check("mv_g1_pressed", 16'(is_pressed), 16'd1);
    check("mv_g1_src_valid", 16'(src_valid), 16'd1);
    check("mv_g1_src", 16'({src_x, src_y}), 16'h23);
    send(1'b0, 1'b1, K_G);
    check("mv_pressed_pulse", 16'(is_pressed), 16'd0);
    tap(K_D);
    tap(K_D);
    tap(K_D);
    check("mv_no_early_move", 16'(move_valid), 16'd0);
    send(1'b0, 1'b0, K_G);
    check("mv_move_valid", 16'(move_valid), 16'd1);
    check("mv_pressed2", 16'(is_pressed), 16'd1);
    check("mv_src", 16'({src_x, src_y}), 16'h23);
    check("mv_dst", 16'({dst_x, dst_y}), 16'h53);
    idle(1);
    check("mv_pulse_end", 16'(move_valid), 16'd0);
    check("mv_src_valid_after", 16'(src_valid), 16'd0);
    check("mv_dst_hold", 16'({dst_x, dst_y}), 16'h53);

    // Cancel paths at (1,1).
    do_reset();
    tap(K_D);
    tap(K_S);
    send(1'b0, 1'b0, K_G);
    check("cx_src_valid", 16'(src_valid), 16'd1);
    send(1'b0, 1'b0, K_G);
    check("cx_same_no_move", 16'(move_valid), 16'd0);
    check("cx_same_cleared", 16'(src_valid), 16'd0);
    idle(1);
    check("cx_same_no_late_move", 16'(move_valid), 16'd0);
    send(1'b0, 1'b0, K_G);
    check("cx_reselect", 16'(src_valid), 16'd1);
    send(1'b0, 1'b0, K_ESC);
    check("cx_esc_cleared", 16'(src_valid), 16'd0);
    check("cx_esc_no_move", 16'(move_valid), 16'd0);
    send(1'b0, 1'b0, K_ESC);
    check("cx_esc_idle", 16'(src_valid), 16'd0);
    send(1'b1, 1'b0, K_G);
    check("cx_ext_g_pressed", 16'(is_pressed), 16'd0);
    check("cx_ext_g_src_valid", 16'(src_valid), 16'd0);

    // Asynchronous reset while D held in SRC_HELD.
    do_reset();
    send(1'b0, 1'b0, K_G);
    send(1'b0, 1'b0, K_D);
    check("ar_pre_x", 16'(cursor_x), 16'd1);
    check("ar_pre_src_valid", 16'(src_valid), 16'd1);
    idle(3);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_async_x", 16'(cursor_x), 16'd0);
    check("ar_async_src_valid", 16'(src_valid), 16'd0);
    check("ar_async_src", 16'({src_x, src_y}), 16'd0);
    idle(2);
    rstn = 1'b1;
    idle(20);
    check("ar_no_step_x", 16'(cursor_x), 16'd0);
    check("ar_no_src", 16'(src_valid), 16'd0);
    check("ar_no_move", 16'(move_valid), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
